// File: rtl/pll_mdrp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_mdrp_ctrl
// Description : Host request/response front end for a PLL dynamic
//               reconfiguration port (MDRP). Walks the PLL's internal
//               address pointer to the requested register (address reset
//               and/or increments), performs one read or write slot, and
//               returns a single-cycle response.
//               Optional feature macro: MDRP_LOCK_WAIT_EN -- after a write,
//               wait for pll_lock to drop and return (bounded by
//               TIMEOUT_CYC) and report a timeout through rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_mdrp_ctrl #(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       mdclk,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  input  logic       pll_lock
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARST     = 3'd1,
    AINC     = 3'd2,
    OP       = 3'd3,
    RDCAP    = 3'd4,
    LOCKWAIT = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [1:0] c_OPC_NOP  = 2'b00;
  localparam logic [1:0] c_OPC_WR   = 2'b01;
  localparam logic [1:0] c_OPC_RD   = 2'b10;
  localparam logic [1:0] c_OPC_ARST = 2'b11;

  // Control state. r_phb marks the second (mdclk high) half of a slot.
  state_t     r_state;
  state_t     w_nxt;
  logic       r_phb;
  logic       w_phb_nxt;
  logic [7:0] r_cur;
  logic [7:0] w_cur_nxt;
  logic [7:0] w_cur_inc;
  logic       r_boot;
  logic       w_boot_nxt;
  logic       w_hs;

  // Captured request.
  logic [7:0] r_target;
  logic [7:0] r_wdata;
  logic       r_write;

  // Registered host and MDRP outputs (one cycle behind the state they reflect).
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_mdclk;
  logic       w_mdclk;
  logic [1:0] r_mdopc;
  logic [1:0] w_mdopc;
  logic       r_mdainc;
  logic       w_mdainc;
  logic [7:0] r_mdwdi;
  logic [7:0] w_mdwdi;

  assign w_cur_inc = r_cur + 8'd1;

`ifdef MDRP_LOCK_WAIT_EN
  localparam int c_TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_seen_low;
  logic               r_err;
  logic               r_rsp_err;
  logic               w_lock_ok;
  logic               w_lock_tmo;

  // Lock re-acquired only after it has been seen low at least once.
  assign w_lock_ok  = r_seen_low & pll_lock;
  assign w_lock_tmo = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1));
  assign rsp_err    = r_rsp_err;

  // Lock-wait bookkeeping: cycle budget, low-seen flag and sticky error.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_tmo_cnt  <= '0;
      r_seen_low <= 1'b0;
      r_err      <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_rsp_err <= (r_state == DONE) & r_err;
      if (r_state == LOCKWAIT) begin
        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        if (!pll_lock) begin
          r_seen_low <= 1'b1;
        end
        if (!w_lock_ok && w_lock_tmo) begin
          r_err <= 1'b1;
        end
      end else begin
        r_tmo_cnt  <= '0;
        r_seen_low <= 1'b0;
      end
      if (w_hs) begin
        r_err <= 1'b0;
      end
    end
  end
`else
  logic w_unused_cfg;

  // Without lock wait the lock input and timeout have no function.
  assign w_unused_cfg = pll_lock ^ (TIMEOUT_CYC > 0);
  assign rsp_err      = 1'b0;
`endif

  // State register; reset lands in IDLE with a pending boot address reset.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_phb   <= 1'b0;
      r_cur   <= 8'd0;
      r_boot  <= 1'b1;
    end else begin
      r_state <= w_nxt;
      r_phb   <= w_phb_nxt;
      r_cur   <= w_cur_nxt;
      r_boot  <= w_boot_nxt;
    end
  end

  // Next-state and MDRP slot encoding; mdclk free-runs outside slots.
  always_comb begin
    w_nxt      = r_state;
    w_phb_nxt  = 1'b0;
    w_cur_nxt  = r_cur;
    w_boot_nxt = r_boot;
    w_hs       = 1'b0;
    w_mdclk    = ~r_mdclk;
    w_mdopc    = c_OPC_NOP;
    w_mdainc   = 1'b0;
    w_mdwdi    = 8'd0;
    case (r_state)
      IDLE: begin
        if (r_boot) begin
          w_nxt = ARST;
        end else if (req_valid && r_req_ready) begin
          w_hs = 1'b1;
          if (req_addr < r_cur) begin
            w_nxt = ARST;
          end else if (req_addr > r_cur) begin
            w_nxt = AINC;
          end else begin
            w_nxt = OP;
          end
        end
      end
      ARST: begin
        w_mdclk = r_phb;
        w_mdopc = c_OPC_ARST;
        if (r_phb) begin
          w_cur_nxt = 8'd0;
          if (r_boot) begin
            w_nxt      = IDLE;
            w_boot_nxt = 1'b0;
          end else if (r_target == 8'd0) begin
            w_nxt = OP;
          end else begin
            w_nxt = AINC;
          end
        end else begin
          w_phb_nxt = 1'b1;
        end
      end
      AINC: begin
        w_mdclk  = r_phb;
        w_mdainc = 1'b1;
        if (r_phb) begin
          w_cur_nxt = w_cur_inc;
          w_nxt     = (w_cur_inc == r_target) ? OP : AINC;
        end else begin
          w_phb_nxt = 1'b1;
        end
      end
      OP: begin
        w_mdclk = r_phb;
        w_mdopc = r_write ? c_OPC_WR : c_OPC_RD;
        w_mdwdi = r_write ? r_wdata : 8'd0;
        if (r_phb) begin
`ifdef MDRP_LOCK_WAIT_EN
          w_nxt = r_write ? LOCKWAIT : RDCAP;
`else
          w_nxt = r_write ? DONE : RDCAP;
`endif
        end else begin
          w_phb_nxt = 1'b1;
        end
      end
      RDCAP: begin
        w_mdclk = r_phb;
        if (r_phb) begin
          w_nxt = DONE;
        end else begin
          w_phb_nxt = 1'b1;
        end
      end
      LOCKWAIT: begin
`ifdef MDRP_LOCK_WAIT_EN
        if (w_lock_ok || w_lock_tmo) begin
          w_nxt = DONE;
        end
`else
        w_nxt = DONE;
`endif
      end
      DONE: begin
        w_nxt = IDLE;
      end
      default: begin
        w_nxt = IDLE;
      end
    endcase
  end

  // Request capture, response registers and registered MDRP outputs.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_target    <= 8'd0;
      r_wdata     <= 8'd0;
      r_write     <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'd0;
      r_mdclk     <= 1'b0;
      r_mdopc     <= c_OPC_NOP;
      r_mdainc    <= 1'b0;
      r_mdwdi     <= 8'd0;
    end else begin
      if (w_hs) begin
        r_target <= req_addr;
        r_wdata  <= req_wdata;
        r_write  <= req_write;
      end
      r_req_ready <= (w_nxt == IDLE);
      r_rsp_valid <= (r_state == DONE);
      // DONE coincides with the last cycle of the RDCAP phase B on the pins.
      if ((r_state == DONE) && !r_write) begin
        r_rsp_rdata <= mdrdo;
      end
      r_mdclk  <= w_mdclk;
      r_mdopc  <= w_mdopc;
      r_mdainc <= w_mdainc;
      r_mdwdi  <= w_mdwdi;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign mdclk     = r_mdclk;
  assign mdopc     = r_mdopc;
  assign mdainc    = r_mdainc;
  assign mdwdi     = r_mdwdi;

endmodule
`default_nettype wire

// File: tb/tb_pll_mdrp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_mdrp_ctrl
// Description : Directed self-checking bench for pll_mdrp_ctrl with a small
//               behavioural PLL register-file model on the MDRP side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_mdrp_ctrl;

  logic       clkin     = 1'b0;
  logic       resetn    = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr  = 8'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       pll_lock  = 1'b1;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mdclk;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;

  int n_assert = 0;
  int n_fail   = 0;

  pll_mdrp_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clkin     (clkin),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mdclk     (mdclk),
    .mdopc     (mdopc),
    .mdainc    (mdainc),
    .mdwdi     (mdwdi),
    .mdrdo     (mdrdo),
    .pll_lock  (pll_lock)
  );

  always #5 clkin = ~clkin;

  // PLL register file model: acts on the rising edge of mdclk.
  logic [7:0] mem [256];
  logic [7:0] m_addr = 8'hEE;
  logic [7:0] m_rd   = 8'h00;
  logic       m_init = 1'b0;

  always @(posedge mdclk) begin
    if (!m_init) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
      mem[3] = 8'h5C;
      m_init = 1'b1;
    end
    if (mdopc == 2'b11)      m_addr = 8'd0;
    else if (mdainc)         m_addr = m_addr + 8'd1;
    else if (mdopc == 2'b01) mem[m_addr] = mdwdi;
    else if (mdopc == 2'b10) m_rd = mem[m_addr];
  end

  assign mdrdo = m_rd;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Release-from-reset sequence: count cycles to ready and ARST cycles seen.
  task automatic wait_boot(output int cyc, output int n11, output int nrsp);
    cyc  = 0;
    n11  = 0;
    nrsp = 0;
    do begin
      tick();
      cyc++;
      if (mdopc == 2'b11) n11++;
      if (rsp_valid) nrsp++;
    end while (!req_ready && cyc < 20);
  endtask

  // One host transaction; returns latency and slot counts seen on MDRP.
  task automatic do_req(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output int na, output int ni,
                        output int nw, output int nr, output int nrdy,
                        output logic [7:0] wd, output logic [7:0] rd, output logic er);
    int  k;
    bit  got;
    lat = 0; na = 0; ni = 0; nw = 0; nr = 0; nrdy = 0;
    wd = 8'd0; rd = 8'd0; er = 1'b0; got = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    k = 0;
    while (!req_ready && k < 50) begin
      tick();
      k++;
    end
    tick();
    req_valid = 1'b0;
    while (!got && lat < 300) begin
      tick();
      lat++;
      if (mdclk) begin
        if (mdopc == 2'b11) na++;
        if (mdainc) ni++;
        if (mdopc == 2'b01) begin
          nw++;
          wd = mdwdi;
        end
        if (mdopc == 2'b10) nr++;
      end
      if (rsp_valid) begin
        got = 1'b1;
        rd  = rsp_rdata;
        er  = rsp_err;
        chk("ready_with_rsp", 32'(req_ready), 32'd1);
      end else if (req_ready) begin
        nrdy++;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    tick();
    chk("rsp_pulse_width", 32'(rsp_valid), 32'd0);
  endtask

  initial begin : main
    int lat, na, ni, nw, nr, nrdy, cyc, n11, nrsp, k;
    logic [7:0] wd, rd;
    logic       er;

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, mdclk, mdopc, mdainc, mdwdi}), 32'd0);
    resetn = 1'b1;
    wait_boot(cyc, n11, nrsp);
    chk("boot_ready", 32'(req_ready), 32'd1);
    chk("boot_cycles", 32'(cyc), 32'd3);
    chk("boot_arst_cycles", 32'(n11), 32'd2);
    chk("boot_no_rsp", 32'(nrsp), 32'd0);
    chk("boot_model_addr", 32'(m_addr), 32'd0);

    // Write at the current address
    do_req(1'b1, 8'h00, 8'hA5, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("wr0_latency", 32'(lat), 32'd3);
    chk("wr0_slots", 32'({8'(na), 8'(ni), 8'(nw), 8'(nr)}), 32'h0000_0100);
    chk("wr0_wdi", 32'(wd), 32'hA5);
    chk("wr0_busy_ready", 32'(nrdy), 32'd0);
    chk("wr0_err", 32'(er), 32'd0);
    chk("wr0_model_mem", 32'(mem[0]), 32'hA5);

    // Read forward by three increments
    do_req(1'b0, 8'h03, 8'h00, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("rd3_latency", 32'(lat), 32'd11);
    chk("rd3_slots", 32'({8'(na), 8'(ni), 8'(nw), 8'(nr)}), 32'h0003_0001);
    chk("rd3_rdata", 32'(rd), 32'h5C);
    chk("rd3_model_addr", 32'(m_addr), 32'h03);

    // Write forward by two increments
    do_req(1'b1, 8'h05, 8'h3C, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("wr5_latency", 32'(lat), 32'd7);
    chk("wr5_slots", 32'({8'(na), 8'(ni), 8'(nw), 8'(nr)}), 32'h0002_0100);
    chk("wr5_model_mem", 32'(mem[5]), 32'h3C);
    chk("rdata_held_after_write", 32'(rsp_rdata), 32'h5C);

    // Read backwards: address reset then one increment
    do_req(1'b0, 8'h01, 8'h00, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("rd1_latency", 32'(lat), 32'd9);
    chk("rd1_slots", 32'({8'(na), 8'(ni), 8'(nw), 8'(nr)}), 32'h0101_0001);
    chk("rd1_rdata", 32'(rd), 32'hC2);
    chk("rd1_model_addr", 32'(m_addr), 32'h01);

    // Read back the earlier write
    do_req(1'b0, 8'h05, 8'h00, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("rd5_latency", 32'(lat), 32'd13);
    chk("rd5_rdata", 32'(rd), 32'h3C);

    // Target 0 from non-zero: address reset goes straight to the op slot
    do_req(1'b1, 8'h00, 8'h77, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("wr0b_latency", 32'(lat), 32'd5);
    chk("wr0b_slots", 32'({8'(na), 8'(ni), 8'(nw), 8'(nr)}), 32'h0100_0100);
    chk("wr0b_model_mem", 32'(mem[0]), 32'h77);

    // Held req_valid: second request accepted the cycle after return to IDLE
    chk("held_ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h00;
    tick();
    k = 0;
    do begin
      tick();
      k++;
    end while (!rsp_valid && k < 20);
    chk("held_first_latency", 32'(k), 32'd5);
    chk("held_first_rdata", 32'(rsp_rdata), 32'h77);
    tick();
    k++;
    chk("held_second_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    do begin
      tick();
      k++;
    end while (!rsp_valid && k < 40);
    chk("held_second_latency", 32'(k), 32'd11);

    // Reset in the middle of the increment phase of a read
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h10;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("mid_ainc_active", 32'({mdclk, mdainc}), 32'h3);
    resetn = 1'b0;
    #1;
    chk("midreset_outputs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, mdclk, mdopc, mdainc, mdwdi}), 32'd0);
    repeat (2) tick();
    chk("midreset_hold", 32'({req_ready, rsp_valid, mdclk, mdopc, mdainc}), 32'd0);
    resetn = 1'b1;
    wait_boot(cyc, n11, nrsp);
    chk("reboot_cycles", 32'(cyc), 32'd3);
    chk("reboot_arst_cycles", 32'(n11), 32'd2);
    chk("reboot_no_rsp", 32'(nrsp), 32'd0);
    chk("reboot_model_addr", 32'(m_addr), 32'd0);

    do_req(1'b0, 8'h03, 8'h00, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("post_reset_rd3_latency", 32'(lat), 32'd11);
    chk("post_reset_rd3_rdata", 32'(rd), 32'h5C);

`ifdef MDRP_LOCK_WAIT_EN
    // Lock drops and returns after about 40 cycles
    fork
      begin
        repeat (5) @(posedge clkin);
        #1 pll_lock = 1'b0;
        repeat (40) @(posedge clkin);
        #1 pll_lock = 1'b1;
      end
    join_none
    do_req(1'b1, 8'h03, 8'h11, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("lock_ok_err", 32'(er), 32'd0);
    chk("lock_ok_latency", 32'(lat >= 40 && lat < 60), 32'd1);

    // Lock never returns: timeout error
    fork
      begin
        repeat (5) @(posedge clkin);
        #1 pll_lock = 1'b0;
      end
    join_none
    do_req(1'b1, 8'h03, 8'h22, lat, na, ni, nw, nr, nrdy, wd, rd, er);
    chk("lock_tmo_err", 32'(er), 32'd1);
    chk("lock_tmo_latency", 32'(lat >= 100 && lat <= 110), 32'd1);
    pll_lock = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_mdrp_ctrl.md
PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 20000: clkin cycles allowed for a lock re-acquire before error.
REQ-002 SHALL have ports: clkin  in  1  system clock, all logic on rising edge; resetn  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: req_valid in 1, req_ready out 1, req_write in 1 (1=write, 0=read), req_addr in 8, req_wdata in 8: host request channel.
REQ-004 SHALL have ports: rsp_valid out 1 (one-cycle pulse), rsp_rdata out 8, rsp_err out 1: host response.
REQ-005 SHALL have ports: mdclk out 1, mdopc out 2, mdainc out 1, mdwdi out 8, mdrdo in 8, pll_lock in 1: PLL dynamic-reconfiguration port and lock.

Function
REQ-006 SHALL drive the MDRP port in slots of 2 clkin cycles: phase A mdclk=0 with mdopc/mdainc/mdwdi updated; phase B mdclk=1, outputs held stable.
REQ-007 SHALL encode mdopc: 00 nop, 01 write, 10 read, 11 address reset (PLL address becomes 0).
REQ-008 SHALL advance the PLL address by 1 per slot with mdainc=1 and mdopc=00; address wraps 255->0.
REQ-009 SHALL track the PLL address in an 8-bit counter cur_addr, reset value 0, mirroring every address reset and increment it issues.
REQ-010 SHALL assert req_ready only in IDLE; handshake completes on the clkin edge where req_valid and req_ready are both 1; req_addr/req_wdata/req_write are captured then.
REQ-011 SHALL use states IDLE, ARST, AINC, OP, RDCAP, LOCKWAIT, DONE.
REQ-012 IDLE->ARST if target < cur_addr; IDLE->AINC if target > cur_addr; IDLE->OP if equal.
REQ-013 ARST: one slot mdopc=11, cur_addr:=0, then AINC (or OP if target=0).
REQ-014 AINC: one slot per increment until cur_addr=target, then OP.
REQ-015 OP: one slot with mdopc=01 and mdwdi=wdata (write) or mdopc=10 (read); write->LOCKWAIT/DONE per REQ-024, read->RDCAP.
REQ-016 RDCAP: one nop slot; mdrdo captured into rsp_rdata on the last clkin of that slot's phase B; then DONE.
REQ-017 DONE: rsp_valid=1 for exactly one clkin cycle, then IDLE; rsp_rdata held until next read capture; rsp_err valid with rsp_valid.
REQ-018 Latency, write with target=cur_addr and lock wait compiled out: rsp_valid exactly 3 clkin cycles after handshake; each extra slot adds 2.
REQ-019 All MDRP outputs outside an active slot: mdopc=00, mdainc=0, mdwdi=0, mdclk keeps toggling.
REQ-020 A new request SHALL NOT be accepted while busy; req_valid held by host is accepted the cycle after return to IDLE.

Reset
REQ-021 resetn low SHALL immediately force: state IDLE, cur_addr=0, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, mdclk=0, mdopc=00, mdainc=0, mdwdi=0.
REQ-022 After resetn rises, SHALL issue one ARST slot before asserting req_ready, so PLL address and cur_addr agree.
REQ-023 Reset mid-transaction SHALL abandon it with no rsp_valid pulse.

Configuration
REQ-024 Macro MDRP_LOCK_WAIT_EN: defined -> after a write OP, LOCKWAIT waits for pll_lock to go 0 then 1; if not 1 within TIMEOUT_CYC clkin cycles, go DONE with rsp_err=1; else DONE with rsp_err=0. Undefined -> write OP goes straight to DONE, rsp_err tied 0, pll_lock unused.

Verification
REQ-025 After reset release: one slot mdopc=11, then req_ready=1; all outputs at REQ-021 values during reset.
REQ-026 Write addr 0x00 data 0xA5 -> one slot mdopc=01 mdwdi=0xA5, rsp_valid 3 cycles after handshake (lock wait out).
REQ-027 Read addr 0x03 from cur_addr 0, model mdrdo=0x5C at 0x03 -> 3 mdainc slots, read slot, rsp_rdata=0x5C, rsp_valid 11 cycles after handshake.
REQ-028 Read addr 0x01 after access at 0x05 -> ARST slot then 1 mdainc slot, cur_addr=1.
REQ-029 With MDRP_LOCK_WAIT_EN, TIMEOUT_CYC=100: lock drops and returns after 40 cycles -> rsp_err=0; lock stays 0 -> rsp_err=1 after 100 cycles.
REQ-030 resetn pulsed low during AINC of a read -> no rsp_valid, outputs to reset values, ARST slot issued after release.
